// File: rtl/axis_frame_source.sv
// AXI4-Stream video frame source: emits frames of 24-bit pixel pairs with SOF on
// tuser and EOL on tlast, honours backpressure and idles GAP_CYCLES between frames.
module axis_frame_source #(
  parameter int unsigned DATA_WIDTH   = 48,
  parameter int unsigned FRAME_WIDTH  = 10,
  parameter int unsigned FRAME_HEIGHT = 10,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [23:0]           solid_color,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned BEATS_PER_LINE  = FRAME_WIDTH / 2;
  localparam int unsigned BEATS_PER_FRAME = BEATS_PER_LINE * FRAME_HEIGHT;
  localparam int unsigned XW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int unsigned YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned BW = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [XW-1:0] XLast   = XW'(BEATS_PER_LINE - 1);
  localparam logic [YW-1:0] YLast   = YW'(FRAME_HEIGHT - 1);
  localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  state_e          state_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [BW-1:0]   beat_q;
  logic [GW-1:0]   gap_q;
  logic [1:0]      pat_q;
  logic [23:0]     color_q;

  logic                  xfer, last_col, last_beat, gap_done, start;
  logic [XW-1:0]         x_nxt;
  logic [YW-1:0]         y_nxt;
  logic [7:0]            sof_fc;
  logic [DATA_WIDTH-1:0] sof_data, beat_data;

  // Pixel pair for one beat; pixel 0 occupies the low 24 bits.
  function automatic logic [DATA_WIDTH-1:0] pixel_pair(input logic [1:0]    pat,
                                                      input logic [23:0]   col,
                                                      input logic [XW-1:0] x,
                                                      input logic [YW-1:0] y,
                                                      input logic [BW-1:0] beat,
                                                      input logic [7:0]    fc);
    logic [7:0] y8, x8;
    y8 = 8'(y);
    x8 = 8'({x, 1'b0});
    case (pat)
      2'd1:    pixel_pair = DATA_WIDTH'({y8, x8 + 8'd1, fc, y8, x8, fc});
      2'd2:    pixel_pair = DATA_WIDTH'({col, col});
      default: pixel_pair = DATA_WIDTH'(beat);
    endcase
  endfunction

  // Position bookkeeping and the frame-start decision.
  always_comb begin
    xfer      = m_axis_tvalid && m_axis_tready;
    last_col  = (x_q == XLast);
    last_beat = last_col && (y_q == YLast);
    gap_done  = (gap_q == GapLast);
    x_nxt     = last_col ? '0 : x_q + XW'(1);
    y_nxt     = last_col ? y_q + YW'(1) : y_q;
    start     = enable && ((state_q == StIdle) ||
                           (state_q == StGap && gap_done) ||
                           (state_q == StActive && xfer && last_beat && GAP_CYCLES == 0));
    // A back-to-back SOF is built in the same cycle frame_cnt increments.
    sof_fc    = (state_q == StActive) ? frame_cnt[7:0] + 8'd1 : frame_cnt[7:0];
    sof_data  = pixel_pair(pattern_sel, solid_color, '0, '0, '0, sof_fc);
    beat_data = pixel_pair(pat_q, color_q, x_nxt, y_nxt, beat_q + BW'(1), frame_cnt[7:0]);
  end

  // Frame FSM with registered stream outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      beat_q        <= '0;
      gap_q         <= '0;
      pat_q         <= '0;
      color_q       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (xfer && last_beat) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
      end
      if (start) begin
        state_q       <= StActive;
        pat_q         <= pattern_sel;
        color_q       <= solid_color;
        x_q           <= '0;
        y_q           <= '0;
        beat_q        <= '0;
        m_axis_tvalid <= 1'b1;
        m_axis_tuser  <= 1'b1;
        m_axis_tlast  <= (BEATS_PER_LINE == 1);
        m_axis_tdata  <= sof_data;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StIdle;
          StActive: begin
            if (xfer) begin
              if (last_beat) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
                gap_q         <= '0;
                state_q       <= (GAP_CYCLES > 0) ? StGap : StIdle;
              end else begin
                x_q          <= x_nxt;
                y_q          <= y_nxt;
                beat_q       <= beat_q + BW'(1);
                m_axis_tuser <= 1'b0;
                m_axis_tlast <= (x_nxt == XLast);
                m_axis_tdata <= beat_data;
              end
            end
          end
          StGap: begin
            if (gap_done) state_q <= StIdle;
            else          gap_q   <= gap_q + GW'(1);
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Randomized self-checking bench for axis_frame_source against a frame-level model.
module tb_axis_frame_source;

  localparam int BPL = 5;
  localparam int FH  = 10;
  localparam int BPF = BPL * FH;
  localparam int GAP = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b1, enable = 1'b0, tready = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_color = 24'd0;
  logic [47:0] tdata;
  logic        tvalid, tuser, tlast, frame_done;
  logic [15:0] frame_cnt;

  // Second instance with no inter-frame gap, free-running pattern 0.
  logic        areset1 = 1'b1, enable1 = 1'b1, tready1 = 1'b1;
  logic [1:0]  pattern_sel1 = 2'd0;
  logic [23:0] solid_color1 = 24'd0;
  logic [47:0] tdata1;
  logic        tvalid1, tuser1, tlast1, frame_done1;
  logic [15:0] frame_cnt1;

  always #5 aclk = ~aclk;

  axis_frame_source dut (
    .aclk(aclk), .areset(areset), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  axis_frame_source #(.GAP_CYCLES(0)) dut_nogap (
    .aclk(aclk), .areset(areset1), .enable(enable1), .pattern_sel(pattern_sel1),
    .solid_color(solid_color1), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
    .m_axis_tready(tready1), .m_axis_tuser(tuser1), .m_axis_tlast(tlast1),
    .frame_done(frame_done1), .frame_cnt(frame_cnt1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Expected beat b of a frame from the pattern rules.
  function automatic logic [47:0] model_beat(input logic [1:0] pat, input logic [23:0] col,
                                             input int b, input int fc);
    int x = b % BPL;
    int y = b / BPL;
    logic [23:0] p0, p1;
    if (pat == 2'd1) begin
      p0 = 24'(((y % 256) << 16) | (((2 * x) % 256) << 8) | (fc % 256));
      p1 = 24'(((y % 256) << 16) | (((2 * x + 1) % 256) << 8) | (fc % 256));
      return {p1, p0};
    end else if (pat == 2'd2) begin
      return {col, col};
    end
    return 48'(b);
  endfunction

  // Model state.
  int          exp_b = 0, exp_fc = 0, frames_seen = 0, gap_idle = 0;
  bit          in_frame = 0, done_exp = 0, gap_track = 0, gap_ok = 0, prev_stall = 0;
  logic [1:0]  pend_pat = 2'd0, lat_pat = 2'd0;
  logic [23:0] pend_col = 24'd0, lat_col = 24'd0;
  logic [47:0] prev_data = 48'd0;
  logic        prev_user = 1'b0, prev_last = 1'b0;

  always @(negedge aclk) begin
    if (areset) begin
      in_frame = 0; exp_b = 0; exp_fc = 0; done_exp = 0; gap_track = 0; prev_stall = 0;
    end else begin
      check_eq("frame_done", 48'(frame_done), 48'(done_exp));
      check_eq("frame_cnt", 48'(frame_cnt), 48'(exp_fc));
      done_exp = 0;
      if (prev_stall) begin
        check_eq("hold_valid", 48'(tvalid), 48'(1));
        check_eq("hold_data", tdata, prev_data);
        check_eq("hold_user", 48'(tuser), 48'(prev_user));
        check_eq("hold_last", 48'(tlast), 48'(prev_last));
      end
      prev_stall = 0;
      if (!in_frame && !tvalid) begin
        pend_pat = pattern_sel;
        pend_col = solid_color;
        gap_idle++;
        if (!enable) gap_ok = 0;
      end
      if (!in_frame && tvalid) begin
        in_frame = 1; exp_b = 0; lat_pat = pend_pat; lat_col = pend_col;
        if (gap_track && gap_ok) check_eq("gap_len", 48'(gap_idle), 48'(GAP));
        gap_track = 0;
      end
      if (in_frame) begin
        check_eq("valid", 48'(tvalid), 48'(1));
        check_eq("data", tdata, model_beat(lat_pat, lat_col, exp_b, exp_fc));
        check_eq("sof", 48'(tuser), 48'(exp_b == 0));
        check_eq("eol", 48'(tlast), 48'((exp_b % BPL) == BPL - 1));
        if (lat_pat == 2'd1 && exp_fc == 1 && exp_b == 17)
          check_eq("coord_x2y3", tdata, 48'h030501030401);
        prev_stall = !tready;
        prev_data = tdata; prev_user = tuser; prev_last = tlast;
        if (tready) begin
          if (exp_b == BPF - 1) begin
            in_frame = 0; exp_b = 0; done_exp = 1; frames_seen++;
            exp_fc = (exp_fc + 1) % 65536;
            gap_track = 1; gap_ok = 1; gap_idle = 0;
            pend_pat = pattern_sel; pend_col = solid_color;
          end else begin
            exp_b++;
          end
        end
      end
    end
  end

  // Gapless instance: beats count 0..49 forever, never a bubble.
  int b1 = 0, b1_checks = 0;
  bit b1_started = 0;
  always @(negedge aclk) begin
    if (!areset1) begin
      if (tvalid1) b1_started = 1;
      if (b1_started && b1_checks < 130) begin
        check_eq("nogap_valid", 48'(tvalid1), 48'(1));
        check_eq("nogap_data", tdata1, 48'(b1));
        check_eq("nogap_sof", 48'(tuser1), 48'(b1 == 0));
        b1 = (b1 + 1) % BPF;
        b1_checks++;
      end
    end
  end

  // tready driver: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
  int bp_mode = 0, bp_phase = 0;
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (bp_mode)
        0: tready = 1'b1;
        1: begin
          tready = ((bp_phase % 4) == 0) || ((bp_phase % 4) == 3);
          bp_phase++;
        end
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic wait_beat(input int n, input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge aclk);
      if (in_frame && exp_b == n) break;
    end
    if (k == 3000) begin
      n_checks++;
      $display("FAIL wait_%s: beat %0d not reached, expected within 3000 cycles", tag, n);
    end
    #1;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int start = frames_seen;
    int k;
    for (k = 0; k < 6000; k++) begin
      @(posedge aclk);
      if (frames_seen >= start + n) break;
    end
    if (k == 6000) begin
      n_checks++;
      $display("FAIL wait_%s: %0d frames not completed, expected within 6000 cycles", tag, n);
    end
    #1;
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    check_eq("rst_valid", 48'(tvalid), 48'(0));
    check_eq("rst_data", tdata, 48'd0);
    check_eq("rst_user", 48'(tuser), 48'(0));
    check_eq("rst_last", 48'(tlast), 48'(0));
    check_eq("rst_done", 48'(frame_done), 48'(0));
    check_eq("rst_fcnt", 48'(frame_cnt), 48'(0));

    @(posedge aclk);
    #1;
    areset = 1'b0; areset1 = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
    @(negedge aclk);
    check_eq("latency_pre", 48'(tvalid), 48'(0));
    @(negedge aclk);
    check_eq("latency_valid", 48'(tvalid), 48'(1));
    check_eq("latency_sof", 48'(tuser), 48'(1));

    // Frame 1 count pattern, frame 2 coordinate pattern with frame_cnt = 1.
    wait_beat(10, "p1sel");
    pattern_sel = 2'd1;
    wait_frames(2, "basic");
    check_eq("fcnt_after2", 48'(frame_cnt), 48'd2);

    // Backpressure 1,0,0,1 on a count frame.
    pattern_sel = 2'd0;
    bp_mode = 1; bp_phase = 0;
    wait_frames(1, "bp");

    // Solid colour latched at SOF, changed mid-frame, random backpressure.
    bp_mode = 2;
    pattern_sel = 2'd2; solid_color = 24'hABCDEF;
    wait_beat(10, "solid");
    solid_color = 24'($urandom);
    wait_frames(1, "solid");

    // Random selections changed at random points in each frame.
    for (int f = 0; f < 3; f++) begin
      pattern_sel = 2'($urandom); solid_color = 24'($urandom);
      wait_beat(int'($urandom_range(1, 40)), "rnd");
      pattern_sel = 2'($urandom); solid_color = 24'($urandom);
      wait_frames(1, "rnd");
    end

    // Drop enable mid-frame: frame completes, then stays idle.
    bp_mode = 0; pattern_sel = 2'd0;
    wait_beat(20, "drop");
    enable = 1'b0;
    wait_frames(1, "drop");
    repeat (30) begin
      @(negedge aclk);
      check_eq("idle_after_drop", 48'(tvalid), 48'(0));
    end
    @(posedge aclk);
    #1;
    enable = 1'b1;

    // Reset mid-frame at beat 17, enable held high.
    wait_beat(17, "rst");
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check_eq("mid_rst_valid", 48'(tvalid), 48'(0));
    check_eq("mid_rst_data", tdata, 48'd0);
    check_eq("mid_rst_user", 48'(tuser), 48'(0));
    check_eq("mid_rst_last", 48'(tlast), 48'(0));
    check_eq("mid_rst_done", 48'(frame_done), 48'(0));
    check_eq("mid_rst_fcnt", 48'(frame_cnt), 48'(0));
    for (int k = 0; k < 10; k++) begin
      if (tvalid) break;
      @(negedge aclk);
    end
    check_eq("restart_valid", 48'(tvalid), 48'(1));
    check_eq("restart_data", tdata, 48'd0);
    check_eq("restart_sof", 48'(tuser), 48'(1));
    check_eq("restart_fcnt", 48'(frame_cnt), 48'(0));
    @(posedge aclk);
    #1;
    wait_frames(1, "restart");
    check_eq("restart_fcnt_done", 48'(frame_cnt), 48'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
